piano_key_ctrl: RTL and testbench

- Keyboard front-end and note scheduler for the tone divider.
- Synchronises and debounces eight raw key inputs (Do4..Do5) and arbitrates among held keys.
- Sequences the divider's 3-bit note select with a gate (tone_en), enforcing a minimum note duration and an inter-note silence gap.
- Output scaler drives the divider's note select directly: 000=Do4 … 111=Do5.

---
 rtl/piano_key_if.sv | 24 ++
 rtl/piano_key_ctrl.sv | 156 +++++++++++++++
 tb/tb_piano_key_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/piano_key_if.sv
`default_nettype none
// ============================================================================
// piano_key_if : key inputs and note-select outputs of the piano key front-end
// Revision     : 1.0
// ============================================================================
interface piano_key_if;
  logic [7:0] keys;
  logic [2:0] scaler;
  logic       tone_en;
  logic       note_start;
  logic       busy;
  logic [7:0] key_state;

  modport master (
    output keys,
    input  scaler, tone_en, note_start, busy, key_state
  );

  modport slave (
    input  keys,
    output scaler, tone_en, note_start, busy, key_state
  );
endinterface
`default_nettype wire

// File: rtl/piano_key_ctrl.sv
`default_nettype none
// ============================================================================
// piano_key_ctrl : key sync/debounce, lowest-key arbitration, note scheduler
// Revision       : 1.0
// ============================================================================
module piano_key_ctrl #(
  parameter int DEB_CYCLES = 500000,
  parameter int MIN_HOLD   = 2500000,
  parameter int GAP_CYCLES = 250000
) (
  input  logic           clk_in,
  input  logic           rst_n,
  piano_key_if.slave     bus
);

  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int HOLD_W = $clog2(MIN_HOLD + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_HOLD - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  logic [7:0]       sync1_q, sync2_q;
  logic [7:0]       key_state_q, key_state_d;
  logic [DEB_W-1:0] deb_cnt_q [8];
  logic [DEB_W-1:0] deb_cnt_d [8];

  state_t            state_q, state_d;
  logic [2:0]        scaler_q, scaler_d;
  logic              tone_en_q, tone_en_d;
  logic              note_start_q, note_start_d;
  logic              busy_q, busy_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

  logic       any_key;
  logic [2:0] sel;
  logic       hold_done;

  // A key toggles once its synced level has disagreed for DEB_CYCLES cycles in a row.
  always_comb begin
    key_state_d = key_state_q;
    for (int i = 0; i < 8; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (sync2_q[i] == key_state_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        key_state_d[i] = ~key_state_q[i];
        deb_cnt_d[i]   = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    any_key = |key_state_q;
    sel     = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (key_state_q[i]) sel = 3'(i);
    end
  end

  // The counter holds completed PLAY cycles, so the note is kept for exactly MIN_HOLD cycles.
  assign hold_done = (hold_cnt_q >= HOLD_LAST);

  always_comb begin
    state_d      = state_q;
    scaler_d     = scaler_q;
    tone_en_d    = tone_en_q;
    note_start_d = 1'b0;
    hold_cnt_d   = hold_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        tone_en_d = 1'b0;
        if (any_key) begin
          scaler_d     = sel;
          tone_en_d    = 1'b1;
          note_start_d = 1'b1;
          hold_cnt_d   = '0;
          state_d      = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (!hold_done) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end else if (!any_key) begin
          tone_en_d = 1'b0;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end else if (sel != scaler_q) begin
          scaler_d     = sel;
          note_start_d = 1'b1;
          hold_cnt_d   = '0;
        end
      end
      ST_GAP: begin
        tone_en_d = 1'b0;
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        tone_en_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      key_state_q  <= '0;
      for (int i = 0; i < 8; i++) deb_cnt_q[i] <= '0;
      state_q      <= ST_IDLE;
      scaler_q     <= 3'd0;
      tone_en_q    <= 1'b0;
      note_start_q <= 1'b0;
      busy_q       <= 1'b0;
      hold_cnt_q   <= '0;
      gap_cnt_q    <= '0;
    end else begin
      sync1_q      <= bus.keys;
      sync2_q      <= sync1_q;
      key_state_q  <= key_state_d;
      for (int i = 0; i < 8; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      state_q      <= state_d;
      scaler_q     <= scaler_d;
      tone_en_q    <= tone_en_d;
      note_start_q <= note_start_d;
      busy_q       <= busy_d;
      hold_cnt_q   <= hold_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign bus.scaler     = scaler_q;
  assign bus.tone_en    = tone_en_q;
  assign bus.note_start = note_start_q;
  assign bus.busy       = busy_q;
  assign bus.key_state  = key_state_q;

endmodule
`default_nettype wire

// File: tb/tb_piano_key_ctrl.sv
`default_nettype none
// ============================================================================
// tb_piano_key_ctrl : directed plus random stimulus against a cycle model
// Revision          : 1.0
// ============================================================================
module tb_piano_key_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int GAP  = 3;

  logic clk_in = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  piano_key_if bus ();

  piano_key_ctrl #(
    .DEB_CYCLES (DEB),
    .MIN_HOLD   (HOLD),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: history of raw keys, per-key disagreement run length,
  // and a scheduler described by mode plus elapsed-cycle counts.
  logic [7:0] hist [$];
  int         run [8];
  logic [7:0] m_ks;
  int         m_mode;      // 0 silent/idle, 1 sounding, 2 enforced silence
  logic [2:0] m_scaler;
  logic       m_ten;
  logic       m_ns;
  int         m_age;       // cycles the current note has been selected
  int         m_gap;       // cycles spent in the silence gap

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    hist.delete();
    hist.push_back(8'h00);
    hist.push_back(8'h00);
    for (int i = 0; i < 8; i++) run[i] = 0;
    m_ks = 8'h00; m_mode = 0; m_scaler = 3'd0; m_ten = 1'b0; m_ns = 1'b0;
    m_age = 0; m_gap = 0;
  endtask

  task automatic model_edge();
    logic [7:0] seen;
    int         lw;
    seen = hist[0];
    lw   = lowest(m_ks);
    for (int i = 0; i < 8; i++) begin
      if (seen[i] != m_ks[i]) begin
        run[i]++;
        if (run[i] == DEB) begin
          m_ks[i] = seen[i];
          run[i]  = 0;
        end
      end else begin
        run[i] = 0;
      end
    end
    void'(hist.pop_front());
    hist.push_back(bus.keys);
    m_ns = 1'b0;
    if (m_mode == 0) begin
      m_ten = 1'b0;
      if (lw >= 0) begin
        m_scaler = 3'(lw); m_ten = 1'b1; m_ns = 1'b1; m_age = 1; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (m_age < HOLD) m_age++;
      else if (lw < 0) begin
        m_ten = 1'b0; m_mode = 2; m_gap = 1;
      end else if (3'(lw) != m_scaler) begin
        m_scaler = 3'(lw); m_ns = 1'b1; m_age = 1;
      end
    end else begin
      if (m_gap >= GAP) m_mode = 0;
      else m_gap++;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all();
    chk("key_state",  bus.key_state,         m_ks);
    chk("scaler",     {5'd0, bus.scaler},     {5'd0, m_scaler});
    chk("tone_en",    {7'd0, bus.tone_en},    {7'd0, m_ten});
    chk("note_start", {7'd0, bus.note_start}, {7'd0, m_ns});
    chk("busy",       {7'd0, bus.busy},       {7'd0, (m_mode != 0)});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      model_edge();
      @(posedge clk_in);
      #1;
      chk_all();
    end
  endtask

  // Called 1 time unit after an edge: reset lands mid-cycle and is checked before the next edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_scaler",    {5'd0, bus.scaler}, 8'h00);
    chk("rst_tone_en",   {7'd0, bus.tone_en}, 8'h00);
    chk("rst_key_state", bus.key_state, 8'h00);
    chk("rst_busy",      {7'd0, bus.busy}, 8'h00);
    chk_all();
    @(posedge clk_in);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    int r;
    int len;
    rst_n    = 1'b0;
    bus.keys = 8'h00;
    model_reset();
    #1;
    chk("reset_state_scaler", {5'd0, bus.scaler}, 8'h00);
    chk_all();
    #11;
    bus.keys = 8'h04;
    rst_n    = 1'b1;
    step(6);
    chk("t1_key_state", bus.key_state, 8'h04);
    step(1);
    chk("t1_scaler", {5'd0, bus.scaler}, 8'h02);
    step(23);
    bus.keys = 8'h00;
    step(20);

    bus.keys = 8'h01; step(3);
    bus.keys = 8'h00; step(12);

    bus.keys = 8'h20; step(8);
    bus.keys = 8'h22; step(30);
    bus.keys = 8'h00; step(20);

    bus.keys = 8'h08; step(10);
    bus.keys = 8'h00; step(20);

    bus.keys = 8'h80; step(40);
    bus.keys = 8'h00; step(9);
    bus.keys = 8'h80; step(20);
    bus.keys = 8'h00; step(20);

    bus.keys = 8'h40; step(10);
    async_reset();
    step(7);
    chk("t6_restart", {5'd0, bus.scaler}, 8'h06);
    step(12);

    bus.keys = 8'hFF; step(30);
    chk("t7_scaler", {5'd0, bus.scaler}, 8'h00);
    bus.keys = 8'h00; step(20);

    for (int s = 0; s < 200; s++) begin
      r = $urandom_range(0, 9);
      if (r <= 2)      bus.keys = 8'h00;
      else if (r <= 6) bus.keys = 8'(1 << $urandom_range(0, 7));
      else if (r <= 8) bus.keys = 8'($urandom);
      else             bus.keys = bus.keys ^ 8'(1 << $urandom_range(0, 7));
      len = (r == 9) ? $urandom_range(1, 4) : $urandom_range(1, 25);
      step(len);
      if (s == 80 || s == 150) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
